// File: rtl/sdrc_wb_arb_pkg.sv
// Shared constants and types for the SDRAM Wishbone arbiter.
// Cycle-type codes, arbitration modes and the arbiter state encoding.
package sdrc_wb_arb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic ARB_RR    = 1'b0;
  localparam logic ARB_FIXED = 1'b1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } arb_state_e;

  // True when an acked beat with this cycle type ends the owner's transfer.
  function automatic logic cti_last(input logic [2:0] cti);
    return (cti == CTI_CLASSIC) || (cti == CTI_EOB);
  endfunction

endpackage

// File: rtl/sdrc_wb_arb_rr_pick.sv
// Combinational one-hot winner picker: round-robin from ptr_i, or fixed
// priority (index 0 highest). Reused by other multi-port blocks.
module sdrc_rr_pick
  import sdrc_wb_arb_pkg::*;
#(
  parameter int NM = 4
) (
  input  logic [NM-1:0]         req_i,
  input  logic [$clog2(NM)-1:0] ptr_i,
  input  logic                  mode_i,
  output logic [NM-1:0]         gnt_o
);

  logic [$clog2(NM)-1:0] sh;
  logic [2*NM-1:0]       req2;
  logic [2*NM-1:0]       gnt2;
  logic [NM-1:0]         oh;
  logic                  found;

  // Rotate requests so the pointer sits at bit 0, pick the lowest set bit,
  // then rotate the one-hot result back into master numbering.
  always_comb begin
    sh    = (mode_i == ARB_FIXED) ? '0 : ptr_i;
    req2  = {req_i, req_i} >> sh;
    oh    = '0;
    found = 1'b0;
    for (int k = 0; k < NM; k++) begin
      if (!found && req2[k]) begin
        oh[k] = 1'b1;
        found = 1'b1;
      end
    end
    gnt2  = {oh, oh} << sh;
    gnt_o = gnt2[2*NM-1:NM];
  end

endmodule

// File: rtl/sdrc_wb_arb.sv
// NM-port Wishbone arbiter in front of the SDRAM controller slave port.
// Optional watchdog enabled by defining SDRC_ARB_TIMEOUT_EN.
module sdrc_wb_arb
  import sdrc_wb_arb_pkg::*;
#(
  parameter int NM = 4,
  parameter int AW = 30,
  parameter int DW = 32,
  parameter int TW = 8,
  localparam int SW = DW / 8,
  localparam int PW = $clog2(NM)
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [NM-1:0]      m_wb_cyc_i,
  input  logic [NM-1:0]      m_wb_stb_i,
  input  logic [NM-1:0]      m_wb_we_i,
  input  logic [NM*AW-1:0]   m_wb_addr_i,
  input  logic [NM*DW-1:0]   m_wb_dat_i,
  input  logic [NM*SW-1:0]   m_wb_sel_i,
  input  logic [NM*3-1:0]    m_wb_cti_i,
  output logic [NM-1:0]      m_wb_ack_o,
  output logic [NM-1:0]      m_wb_err_o,
  output logic [DW-1:0]      m_wb_dat_o,
  output logic               s_wb_cyc_o,
  output logic               s_wb_stb_o,
  output logic               s_wb_we_o,
  output logic [AW-1:0]      s_wb_addr_o,
  output logic [DW-1:0]      s_wb_dat_o,
  output logic [SW-1:0]      s_wb_sel_o,
  output logic [2:0]         s_wb_cti_o,
  input  logic               s_wb_ack_i,
  input  logic [DW-1:0]      s_wb_dat_i,
  input  logic               cfg_arb_mode,
  input  logic [NM-1:0]      cfg_arb_mask,
  input  logic [TW-1:0]      cfg_arb_timeout,
  output logic [NM-1:0]      arb_gnt_o,
  output logic               arb_to_sts_o
);

  arb_state_e     state_q, state_d;
  logic [NM-1:0]  gnt_q, gnt_d;
  logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]  rr_nxt;
  logic [NM-1:0]  req, win;
  logic           active, rel, to_fire;
  logic           own_cyc, own_stb, own_we;
  logic [AW-1:0]  own_addr;
  logic [DW-1:0]  own_dat;
  logic [SW-1:0]  own_sel;
  logic [2:0]     own_cti;

  assign req    = m_wb_cyc_i & m_wb_stb_i & cfg_arb_mask;
  assign active = (state_q == ST_ACTIVE);

  sdrc_rr_pick #(.NM(NM)) u_pick (
    .req_i  (req),
    .ptr_i  (rr_ptr_q),
    .mode_i (cfg_arb_mode),
    .gnt_o  (win)
  );

  always_comb begin
    own_cyc  = 1'b0;
    own_stb  = 1'b0;
    own_we   = 1'b0;
    own_addr = '0;
    own_dat  = '0;
    own_sel  = '0;
    own_cti  = '0;
    rr_nxt   = '0;
    for (int i = 0; i < NM; i++) begin
      if (gnt_q[i]) begin
        own_cyc  = m_wb_cyc_i[i];
        own_stb  = m_wb_stb_i[i];
        own_we   = m_wb_we_i[i];
        own_addr = m_wb_addr_i[i*AW +: AW];
        own_dat  = m_wb_dat_i[i*DW +: DW];
        own_sel  = m_wb_sel_i[i*SW +: SW];
        own_cti  = m_wb_cti_i[i*3 +: 3];
        rr_nxt   = (i == NM - 1) ? '0 : PW'(i + 1);
      end
    end
  end

`ifdef SDRC_ARB_TIMEOUT_EN
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          to_sts_q;

  // Counter holds the number of completed ACTIVE cycles without ack, so the
  // current cycle is number to_cnt_q + 1.
  assign to_fire = active & own_cyc & ~s_wb_ack_i & (cfg_arb_timeout != '0)
                 & ((to_cnt_q + TW'(1)) == cfg_arb_timeout);

  always_comb begin
    to_cnt_d = to_cnt_q + TW'(1);
    if (!active || s_wb_ack_i) to_cnt_d = '0;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      to_cnt_q <= '0;
      to_sts_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      if (to_fire) to_sts_q <= 1'b1;
    end
  end

  assign arb_to_sts_o = to_sts_q;
`else
  logic unused_cfg_timeout;
  assign unused_cfg_timeout = ^cfg_arb_timeout;
  assign to_fire            = 1'b0;
  assign arb_to_sts_o       = 1'b0;
`endif

  assign rel = active & (~own_cyc | (s_wb_ack_i & cti_last(own_cti)) | to_fire);

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_ACTIVE;
          gnt_d   = win;
        end
      end
      ST_ACTIVE: begin
        if (rel) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          if (cfg_arb_mode == ARB_RR) rr_ptr_d = rr_nxt;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Acks are only forwarded while the owner still holds cyc.
  assign s_wb_cyc_o  = active & own_cyc & ~to_fire;
  assign s_wb_stb_o  = active & own_stb & ~to_fire;
  assign s_wb_we_o   = active & own_we;
  assign s_wb_addr_o = active ? own_addr : '0;
  assign s_wb_dat_o  = active ? own_dat  : '0;
  assign s_wb_sel_o  = active ? own_sel  : '0;
  assign s_wb_cti_o  = active ? own_cti  : '0;
  assign m_wb_ack_o  = (active & own_cyc & s_wb_ack_i) ? gnt_q : '0;
  assign m_wb_err_o  = to_fire ? gnt_q : '0;
  assign m_wb_dat_o  = s_wb_dat_i;
  assign arb_gnt_o   = gnt_q;

endmodule
